// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and constants.
package fetch_pkg;

  localparam int unsigned INSTR_BITS = 32;
  localparam int unsigned PC_INCR    = 4;

  // Reset value of the presented instruction (addi x0, x0, 0).
  localparam logic [INSTR_BITS-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_pc_gen.sv
// Next fetch-PC selection: sequential PC+4 or decode redirect target.
// FETCH_MISALIGN_CHECK_EN: flag misaligned redirects instead of masking them.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = 16
) (
  input  logic [ADDRESS_BITS-1:0] pc,
  input  logic                    next_pc_select,
  input  logic [ADDRESS_BITS-1:0] target_pc,
  output logic [ADDRESS_BITS-1:0] next_pc_c
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                    misaligned_c
`endif
);

  // Word-alignment mask: clears the byte-offset bits of an address.
  localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(PC_INCR - 1);

  logic [ADDRESS_BITS-1:0] seq_pc_c;

  // Sequential successor wraps modulo 2^ADDRESS_BITS.
  assign seq_pc_c = pc + ADDRESS_BITS'(PC_INCR);

`ifdef FETCH_MISALIGN_CHECK_EN
  // Target passes through untouched; a misaligned one is reported to the FSM.
  always_comb begin
    next_pc_c    = next_pc_select ? target_pc : seq_pc_c;
    misaligned_c = next_pc_select && ((target_pc & ~ALIGN_MASK) != '0);
  end
`else
  // Target byte-offset bits are dropped so fetch always stays word aligned.
  always_comb begin
    next_pc_c = next_pc_select ? (target_pc & ALIGN_MASK) : seq_pc_c;
  end
`endif

endmodule : fetch_pc_gen

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, valid/ready handoff to decode.
// FETCH_MISALIGN_CHECK_EN: adds sticky fetch_fault and parks fetch on a misaligned redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned                    ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0]        RESET_PC     = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    next_PC_select,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  input  logic                    decode_ready,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic                    imem_valid,
  input  logic [31:0]             imem_rdata,
  output logic [ADDRESS_BITS-1:0] PC,
  output logic [31:0]             instruction,
  output logic                    instr_valid
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                    fetch_fault
`endif
);

  fetch_state_e            state_q, state_d;
  logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d;
  logic [31:0]             instr_q, instr_d;
  logic                    valid_q, valid_d;
  logic                    req_q, req_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [ADDRESS_BITS-1:0] next_pc_c;
  logic                    parked_c;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic misaligned_c;

  assign parked_c    = fault_q;
  assign fetch_fault = fault_q;
`else
  assign parked_c = 1'b0;
`endif

  fetch_pc_gen #(
    .ADDRESS_BITS (ADDRESS_BITS)
  ) u_pc_gen (
    .pc             (pc_q),
    .next_pc_select (next_PC_select),
    .target_pc      (target_PC),
    .next_pc_c      (next_pc_c)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misaligned_c   (misaligned_c)
`endif
  );

  // Next-state and registered-output logic. The request flop is raised on the
  // edge that enters FETCH so imem_req is visible during the FETCH cycle itself.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    req_d      = 1'b0;
    addr_d     = addr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d    = fault_q;
`endif

    case (state_q)
      FETCH: begin
        if (!parked_c) begin
          if (req_q) begin
            state_d = WAIT;
          end else begin
            // Out of reset nothing has been requested yet: issue it now.
            req_d  = 1'b1;
            addr_d = fetch_pc_q;
          end
        end
      end

      WAIT: begin
        if (imem_valid) begin
          pc_d    = fetch_pc_q;
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = FULL;
        end
      end

      FULL: begin
        if (decode_ready) begin
          valid_d = 1'b0;
          state_d = FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (misaligned_c) begin
            fault_d = 1'b1;
          end else begin
            fetch_pc_d = next_pc_c;
            req_d      = 1'b1;
            addr_d     = next_pc_c;
          end
`else
          fetch_pc_d = next_pc_c;
          req_d      = 1'b1;
          addr_d     = next_pc_c;
`endif
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign PC          = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: latency-programmable imem model plus an
// address-sequence reference model of the fetch stream.
module tb_fetch_unit;

  localparam int unsigned     AW     = 16;
  localparam logic [AW-1:0]   RST_PC = 16'h0000;
  localparam logic [31:0]     NOP    = 32'h0000_0013;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          next_PC_select = 1'b0;
  logic [AW-1:0] target_PC = '0;
  logic          decode_ready = 1'b0;
  logic          imem_valid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [AW-1:0] PC;
  logic [31:0]   instruction;
  logic          instr_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic          fetch_fault;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rel_cyc  = 0;
  int lat      = 1;
  logic [AW-1:0] exp_pc = RST_PC;

  fetch_unit #(.ADDRESS_BITS(AW), .RESET_PC(RST_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .next_PC_select (next_PC_select),
    .target_PC      (target_PC),
    .decode_ready   (decode_ready),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .PC             (PC),
    .instruction    (instruction),
    .instr_valid    (instr_valid)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, ~a};
  endfunction

  // Instruction memory: answers each request exactly lat cycles later; reset drops it.
  initial begin : imem_model
    int cnt;
    logic [AW-1:0] addr;
    cnt  = 0;
    addr = '0;
    forever begin
      @(negedge clock);
      imem_valid = 1'b0;
      if (!reset) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(addr);
          end
        end
        if (imem_req) begin
          cnt  = lat;
          addr = imem_addr;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    decode_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset   = 1'b1;
    rel_cyc = cyc;
    exp_pc  = RST_PC;
  endtask

  // One fetched instruction: request, latency, presentation, optional stall, accept.
  task automatic run_txn(input int hold, input logic sel, input logic [AW-1:0] tgt,
                         input int next_lat);
    int t;
    int w;
    bit ok;
    bit extra;
    w = 0;
    while (!imem_req && w < 40) begin
      @(negedge clock);
      w++;
    end
    n_checks++;
    if (imem_req !== 1'b1) begin
      $display("FAIL req_timeout: imem_req=%b required 1", imem_req);
      n_fail++;
      return;
    end
    n_checks++;
    if (imem_addr !== exp_pc) begin
      $display("FAIL req_addr: imem_addr=%h required %h", imem_addr, exp_pc);
      n_fail++;
    end
    t = cyc;
    w = 0;
    extra = 1'b0;
    do begin
      @(negedge clock);
      w++;
      if (imem_req) extra = 1'b1;
    end while (!instr_valid && w < 40);
    n_checks++;
    if (instr_valid !== 1'b1 || extra) begin
      $display("FAIL valid_wait: instr_valid=%b extra_req=%b required 1/0", instr_valid, extra);
      n_fail++;
      return;
    end
    n_checks++;
    if (cyc - t != lat + 1) begin
      $display("FAIL latency: %0d cycles required %0d", cyc - t, lat + 1);
      n_fail++;
    end
    n_checks++;
    if (PC !== exp_pc || instruction !== mem_word(exp_pc)) begin
      $display("FAIL present: PC=%h instr=%h required %h %h", PC, instruction, exp_pc,
               mem_word(exp_pc));
      n_fail++;
    end
    ok = 1'b1;
    repeat (hold) begin
      decode_ready   = 1'b0;
      next_PC_select = 1'($urandom_range(0, 1));
      target_PC      = AW'($urandom);
      @(negedge clock);
      if (PC !== exp_pc || instruction !== mem_word(exp_pc) || instr_valid !== 1'b1 ||
          imem_req !== 1'b0)
        ok = 1'b0;
    end
    if (hold > 0) begin
      n_checks++;
      if (!ok) begin
        $display("FAIL stall_freeze: outputs changed PC=%h valid=%b req=%b required %h 1 0",
                 PC, instr_valid, imem_req, exp_pc);
        n_fail++;
      end
    end
    decode_ready   = 1'b1;
    next_PC_select = sel;
    target_PC      = tgt;
    lat            = next_lat;
    @(negedge clock);
    decode_ready   = 1'b0;
    next_PC_select = 1'($urandom_range(0, 1));
    target_PC      = AW'($urandom);
`ifdef FETCH_MISALIGN_CHECK_EN
    if (sel && tgt[1:0] != 2'b00) begin
      ok = (fetch_fault === 1'b1) && (imem_req === 1'b0) && (instr_valid === 1'b0);
      repeat (8) begin
        @(negedge clock);
        if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) ok = 1'b0;
      end
      n_checks++;
      if (!ok) begin
        $display("FAIL fault_park: fault=%b req=%b valid=%b required 1 0 0",
                 fetch_fault, imem_req, instr_valid);
        n_fail++;
      end
      return;
    end
`endif
    exp_pc = sel ? (tgt & 16'hFFFC) : exp_pc + 16'd4;
    n_checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== exp_pc) begin
      $display("FAIL next_req: req=%b valid=%b addr=%h required 1 0 %h",
               imem_req, instr_valid, imem_addr, exp_pc);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      $display("FAIL reset_ctrl: req=%b valid=%b required 0 0", imem_req, instr_valid);
      n_fail++;
    end
    n_checks++;
    if (PC !== RST_PC || imem_addr !== RST_PC || instruction !== NOP) begin
      $display("FAIL reset_data: PC=%h addr=%h instr=%h required %h %h %h",
               PC, imem_addr, instruction, RST_PC, RST_PC, NOP);
      n_fail++;
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    n_checks++;
    if (fetch_fault !== 1'b0) begin
      $display("FAIL reset_fault: fetch_fault=%b required 0", fetch_fault);
      n_fail++;
    end
`endif
  endtask

  // L=1, decode always ready, sequential: requests at 0,3,6 to 0,4,8; valid at cycle 2.
  task automatic test_basic();
    int n_req;
    int req_cyc[3];
    logic [AW-1:0] req_addr[3];
    int first_iv;
    logic [AW-1:0] first_pc;
    n_req = 0;
    first_iv = -1;
    first_pc = '1;
    lat = 1;
    do_reset();
    decode_ready = 1'b1;
    next_PC_select = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      if (imem_req) begin
        if (n_req < 3) begin
          req_cyc[n_req]  = cyc - rel_cyc - 1;
          req_addr[n_req] = imem_addr;
        end
        n_req++;
      end
      if (instr_valid && first_iv < 0) begin
        first_iv = cyc - rel_cyc - 1;
        first_pc = PC;
      end
    end
    decode_ready = 1'b0;
    n_checks++;
    if (n_req != 3) begin
      $display("FAIL basic_req_count: %0d required 3", n_req);
      n_fail++;
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (req_cyc[i] != 3 * i || req_addr[i] !== AW'(4 * i)) begin
          $display("FAIL basic_req%0d: cycle %0d addr %h required %0d %h",
                   i, req_cyc[i], req_addr[i], 3 * i, AW'(4 * i));
          n_fail++;
        end
      end
    end
    n_checks++;
    if (first_iv != 2 || first_pc !== RST_PC) begin
      $display("FAIL basic_first_valid: cycle %0d PC %h required 2 %h", first_iv, first_pc, RST_PC);
      n_fail++;
    end
  endtask

  // Stall with toggling redirect inputs, redirect to 0x0120, wrap from 0xFFFC.
  task automatic test_redirect_wrap();
    lat = 2;
    do_reset();
    run_txn(5, 1'b1, 16'h0120, 1);
    run_txn(0, 1'b1, 16'hFFFC, 3);
    run_txn(2, 1'b0, 16'h1234, 1);
    run_txn(0, 1'b0, 16'h0000, 1);
    n_checks++;
    if (exp_pc !== 16'h0004) begin
      $display("FAIL wrap_model: model pc %h required 0004", exp_pc);
      n_fail++;
    end
  endtask

  // Reset mid-WAIT with L=4: the pending response must never surface.
  task automatic test_reset_in_wait();
    int w;
    bit stale;
    lat = 4;
    do_reset();
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (!imem_req && w < 10);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || PC !== RST_PC || instruction !== NOP) begin
      $display("FAIL wait_reset: valid=%b req=%b PC=%h instr=%h required 0 0 %h %h",
               instr_valid, imem_req, PC, instruction, RST_PC, NOP);
      n_fail++;
    end
    lat = 2;
    reset = 1'b1;
    rel_cyc = cyc;
    exp_pc = RST_PC;
    stale = 1'b0;
    w = 0;
    do begin
      @(negedge clock);
      w++;
      if (instr_valid) stale = 1'b1;
    end while (!imem_req && w < 10);
    n_checks++;
    if (stale || imem_req !== 1'b1 || cyc - rel_cyc - 1 != 0 || imem_addr !== RST_PC) begin
      $display("FAIL wait_restart: stale=%b req=%b cycle=%0d addr=%h required 0 1 0 %h",
               stale, imem_req, cyc - rel_cyc - 1, imem_addr, RST_PC);
      n_fail++;
    end
    run_txn(0, 1'b0, 16'h0000, 1);
  endtask

  // Random latency, stall length and redirects against the address model.
  task automatic test_random();
    logic [AW-1:0] tgt;
    lat = $urandom_range(1, 4);
    do_reset();
    for (int i = 0; i < 25; i++) begin
      tgt = AW'($urandom);
`ifdef FETCH_MISALIGN_CHECK_EN
      tgt = tgt & 16'hFFFC;
`endif
      run_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), tgt, $urandom_range(1, 4));
    end
  endtask

  // Redirect to 0x0122: masked to 0x0120, or sticky fault with the check enabled.
  task automatic test_misalign();
    lat = 1;
    do_reset();
    run_txn(0, 1'b1, 16'h0122, 1);
`ifndef FETCH_MISALIGN_CHECK_EN
    n_checks++;
    if (exp_pc !== 16'h0120) begin
      $display("FAIL misalign_model: model pc %h required 0120", exp_pc);
      n_fail++;
    end
    run_txn(0, 1'b0, 16'h0000, 1);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_redirect_wrap();
    test_reset_in_wait();
    test_random();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding `decode`: holds the architectural fetch PC, issues one instruction-memory read at a time, and presents `PC`/`instruction` to decode with a valid/ready handshake. It consumes decode's `next_PC_select`/`target_PC` redirect outputs at the moment decode accepts an instruction. It is the producer end of the fetch→decode interface.

## Interface
- `ADDRESS_BITS`, 16: fetch address width; matches `decode`.
- `RESET_PC`, 0: fetch address loaded at reset.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `next_PC_select` in 1: from decode; 1 selects `target_PC`, 0 selects PC+4.
- `target_PC` in ADDRESS_BITS: redirect target from decode.
- `decode_ready` in 1: decode accepts the presented instruction this cycle.
- `imem_req` out 1: one-cycle read request pulse.
- `imem_addr` out ADDRESS_BITS: read address; valid while `imem_req`=1.
- `imem_valid` in 1: read data valid; one pulse per request, latency ≥1 cycle.
- `imem_rdata` in 32: instruction word.
- `PC` out ADDRESS_BITS: address of the presented instruction.
- `instruction` out 32: presented instruction word.
- `instr_valid` out 1: `PC`/`instruction` are valid for decode.
- `fetch_fault` out 1: misaligned redirect flag; present only with `FETCH_MISALIGN_CHECK_EN`.

## Operation
- State machine with three states: FETCH, WAIT, FULL.
- FETCH: drive `imem_req`=1, `imem_addr`=fetch_pc for exactly one cycle, then go to WAIT.
- WAIT: on `imem_valid`=1, register `imem_rdata` into `instruction` and fetch_pc into `PC`, set `instr_valid`, then go to FULL. Otherwise stay in WAIT; there is no timeout.
- FULL: hold `PC`/`instruction`/`instr_valid` stable until `decode_ready`=1.
  - On acceptance, fetch_pc becomes `target_PC` if `next_PC_select`=1, else `PC`+4.
  - Then clear `instr_valid` and go to FETCH.
- `next_PC_select`/`target_PC` are sampled only on the FULL∧`decode_ready` cycle and ignored otherwise.
- `imem_valid` is ignored outside WAIT. Only one request is ever outstanding.
- PC+4 arithmetic is modulo 2^ADDRESS_BITS: 16'hFFFC+4 wraps to 16'h0000.
- The instruction memory shares `reset`. Responses to requests issued before a reset are never returned.

## Timing
- Reset values:
  - state FETCH.
  - fetch_pc, `PC`, `imem_addr` = RESET_PC.
  - `instruction` = 32'h00000013 (NOP).
  - `imem_req`, `instr_valid`, `fetch_fault` = 0.
- Reset asserted in any state returns to the reset values on the next edge. An in-flight WAIT is abandoned.
- First `imem_req` is in the first cycle after `reset` deasserts.
- Latency: with memory latency L, the request goes out in cycle t and `instr_valid` rises in cycle t+L+1.
- After acceptance in cycle a, the next `imem_req` is in a+1.
- Throughput with L=1 and decode always ready: one instruction per 3 cycles.
- `instr_valid`=1 and `decode_ready`=0: all outputs are frozen, including while `next_PC_select` toggles.
- `imem_valid` arriving in the same cycle as `imem_req` is invalid (latency ≥1). The bench must not drive it.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect (`next_PC_select`=1) with `target_PC[1:0]`≠0 sets sticky `fetch_fault`=1 on the next edge.
  - The FSM then parks in FETCH with `imem_req` held at 0 until reset.
  - `instr_valid` stays 0.
- Not defined:
  - The `fetch_fault` port is absent.
  - `target_PC[1:0]` is forced to 2'b00 when loaded into fetch_pc; fetch continues.

## Structure
- Package `fetch_pkg`: state encoding (FETCH, WAIT, FULL), NOP constant 32'h00000013, PC increment constant 4.
- Sub-module `fetch_pc_gen`: combinational next-fetch-PC select (PC+4 vs target, alignment masking/fault detect). The FSM and registers stay in `fetch_unit`.

## Test plan
- Reset release, RESET_PC=0, L=1, decode always ready, `next_PC_select`=0 → `imem_addr` sequence 0x0000, 0x0004, 0x0008; `instr_valid` rises in cycle 2 with `PC`=0x0000.
- Decode holds `decode_ready`=0 for 5 cycles while `next_PC_select` toggles → `PC`/`instruction` constant; no `imem_req` issued.
- Accept with `next_PC_select`=1, `target_PC`=0x0120 → next `imem_addr`=0x0120 one cycle after acceptance.
- `PC`=0xFFFC accepted, no redirect → next `imem_addr`=0x0000.
- `reset` asserted during WAIT (L=4), then released → `instr_valid`=0, first new request at RESET_PC, no stale data presented.
- Redirect to 0x0122: with `FETCH_MISALIGN_CHECK_EN` → `fetch_fault`=1, no further `imem_req`; without → `imem_addr`=0x0120.
